fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded at reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning instruction injected into decode on flush/reset (addi x0,x0,0).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the stall and flush event counters.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports clk first and rst_n second.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 SS1  input  1  PC enable from hazard unit (1 = advance, 0 = hold PC).
REQ-008 SS2  input  1  IF/ID register enable from hazard unit (1 = load, 0 = hold).
REQ-009 PCSrc  input  1  branch/jump taken in EX (redirect + flush).
REQ-010 PCTargetE  input  32  redirect target from EX.
REQ-011 InstrF  input  32  instruction memory read data for address PCF (combinational, same cycle).
REQ-012 PCF  output  32  current fetch PC, drives instruction memory address.
REQ-013 InstrD  output  32  IF/ID instruction.
REQ-014 PCD  output  32  IF/ID PC.
REQ-015 PCPlus4D  output  32  IF/ID PC+4.
REQ-016 ValidD  output  1  IF/ID contents are a real fetched instruction.
REQ-017 stall_cnt  output  CNT_W  count of PC-stall cycles.
REQ-018 flush_cnt  output  CNT_W  count of redirect/flush cycles.

Function
REQ-019 PCPlus4F SHALL be PCF + 32'd4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-020 Next PC priority SHALL be: PCSrc=1 -> PCTargetE; else SS1=1 -> PCPlus4F; else hold PCF.
REQ-021 PCSrc SHALL override SS1=0: a redirect is never lost to a simultaneous stall.
REQ-022 IF/ID priority SHALL be: PCSrc=1 -> InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0; else SS2=1 -> load InstrF, PCF, PCPlus4F, ValidD=1; else hold all four.
REQ-023 PCSrc SHALL flush IF/ID regardless of SS2.
REQ-024 Redirect latency SHALL be one cycle: PCF equals PCTargetE on the edge after PCSrc is sampled high; the wrong-path instruction fetched that cycle never reaches ValidD=1.
REQ-025 With SS1=SS2=1 and PCSrc=0, throughput SHALL be one instruction per cycle, InstrD(n+1) = InstrF(n).
REQ-026 SS1=0, SS2=0 SHALL freeze PCF and the IF/ID register bit-exactly for as many cycles as asserted.
REQ-027 SS1=0 with SS2=1 (not produced by the hazard unit) SHALL still load IF/ID from the held PCF; no error flag.
REQ-028 stall_cnt SHALL increment by 1 on each edge where SS1=0 and PCSrc=0, saturating at 2^CNT_W-1.
REQ-029 flush_cnt SHALL increment by 1 on each edge where PCSrc=1, saturating at 2^CNT_W-1.
REQ-030 No output SHALL depend combinationally on any input except through registered state (PCF drives memory; InstrF is only registered).

Reset
REQ-031 rst_n low SHALL immediately, without clk, set PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, stall_cnt=0, flush_cnt=0.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL discard pending state; first edge after rst_n rises SHALL fetch from RESET_PC.
REQ-033 Reset deassertion SHALL be synchronized externally; block samples inputs normally from the first rising edge with rst_n=1.

Verification
REQ-034 Reset then 3 cycles SS1=SS2=1, InstrF=PC-derived -> PCF 0x0,0x4,0x8,0xC; InstrD lags one cycle; ValidD=1 from second edge.
REQ-035 At PCF=0x8 drive SS1=SS2=0 for 2 cycles -> PCF stays 0x8, IF/ID holds PCD=0x4, stall_cnt=2; release -> PCF=0xC next edge.
REQ-036 PCSrc=1, PCTargetE=0x100, SS1=SS2=0 simultaneously -> next edge PCF=0x100, InstrD=0x0000_0013, ValidD=0, flush_cnt=1, stall_cnt unchanged.
REQ-037 Force PCF=0xFFFF_FFFC via PCSrc target, run one cycle -> PCF=0x0000_0000, PCPlus4D=0x0000_0000 captured.
REQ-038 CNT_W=4, hold SS1=0 for 20 cycles -> stall_cnt saturates at 15.
REQ-039 Assert rst_n low between clock edges during a redirect -> all outputs at reset values before next edge; after release PCF=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage hazard, redirect, imem and IF/ID signal bundle
interface fetch_stage_if #(
    parameter int CNT_W = 16
);
    logic             SS1;
    logic             SS2;
    logic             PCSrc;
    logic [31:0]      PCTargetE;
    logic [31:0]      InstrF;
    logic [31:0]      PCF;
    logic [31:0]      InstrD;
    logic [31:0]      PCD;
    logic [31:0]      PCPlus4D;
    logic             ValidD;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  SS1, SS2, PCSrc, PCTargetE, InstrF,
        output PCF, InstrD, PCD, PCPlus4D, ValidD, stall_cnt, flush_cnt
    );

    modport slave (
        output SS1, SS2, PCSrc, PCTargetE, InstrF,
        input  PCF, InstrD, PCD, PCPlus4D, ValidD, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, IF/ID pipeline register and stall/flush event counters
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);
    logic [31:0]      pc_q;
    logic [31:0]      pc_plus4;
    logic [31:0]      instr_q;
    logic [31:0]      pcd_q;
    logic [31:0]      pcp4d_q;
    logic             valid_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign pc_plus4 = pc_q + 32'd4;

    // A redirect wins over a stall so the taken branch is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (bus.PCSrc) begin
            pc_q <= bus.PCTargetE;
        end else if (bus.SS1) begin
            pc_q <= pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4d_q <= 32'd0;
            valid_q <= 1'b0;
        end else if (bus.PCSrc) begin
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'd0;
            pcp4d_q <= 32'd0;
            valid_q <= 1'b0;
        end else if (bus.SS2) begin
            instr_q <= bus.InstrF;
            pcd_q   <= pc_q;
            pcp4d_q <= pc_plus4;
            valid_q <= 1'b1;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!bus.SS1 && !bus.PCSrc && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (bus.PCSrc && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign bus.PCF       = pc_q;
    assign bus.InstrD    = instr_q;
    assign bus.PCD       = pcd_q;
    assign bus.PCPlus4D  = pcp4d_q;
    assign bus.ValidD    = valid_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural pipeline model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ss1 = 1'b0;
    logic        ss2 = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] target = 32'd0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    fetch_stage_if #(.CNT_W(16)) bus ();
    fetch_stage_if #(.CNT_W(4))  bus4 ();

    assign bus.SS1        = ss1;
    assign bus.SS2        = ss2;
    assign bus.PCSrc      = pcsrc;
    assign bus.PCTargetE  = target;
    assign bus.InstrF     = mem(bus.PCF);
    assign bus4.SS1       = ss1;
    assign bus4.SS2       = ss2;
    assign bus4.PCSrc     = pcsrc;
    assign bus4.PCTargetE = target;
    assign bus4.InstrF    = mem(bus4.PCF);

    fetch_stage #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    fetch_stage #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.master));

    logic [31:0] m_pc, m_instr, m_pcd, m_p4d;
    logic        m_valid;
    int          m_sc, m_fc, m_sc4, m_fc4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0000_0013;
        m_pcd   = 32'h0;
        m_p4d   = 32'h0;
        m_valid = 1'b0;
        m_sc    = 0;
        m_fc    = 0;
        m_sc4   = 0;
        m_fc4   = 0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".PCF"},      bus.PCF,      m_pc);
        chk({ph, ".InstrD"},   bus.InstrD,   m_instr);
        chk({ph, ".PCD"},      bus.PCD,      m_pcd);
        chk({ph, ".PCPlus4D"}, bus.PCPlus4D, m_p4d);
        chk({ph, ".ValidD"},   {31'd0, bus.ValidD}, {31'd0, m_valid});
        chk({ph, ".stall"},    32'(bus.stall_cnt),  32'(m_sc));
        chk({ph, ".flush"},    32'(bus.flush_cnt),  32'(m_fc));
        chk({ph, ".stall4"},   32'(bus4.stall_cnt), 32'(m_sc4));
        chk({ph, ".flush4"},   32'(bus4.flush_cnt), 32'(m_fc4));
    endtask

    // One clock: the model applies the architectural rules to the inputs set up before the edge.
    task automatic step(input string ph);
        logic [31:0] f, p4;
        f  = mem(m_pc);
        p4 = m_pc + 32'd4;
        if (!ss1 && !pcsrc) begin
            m_sc  = (m_sc  < 65535) ? m_sc + 1  : m_sc;
            m_sc4 = (m_sc4 < 15)    ? m_sc4 + 1 : m_sc4;
        end
        if (pcsrc) begin
            m_fc  = (m_fc  < 65535) ? m_fc + 1  : m_fc;
            m_fc4 = (m_fc4 < 15)    ? m_fc4 + 1 : m_fc4;
        end
        if (pcsrc) begin
            m_instr = 32'h0000_0013;
            m_pcd   = 32'h0;
            m_p4d   = 32'h0;
            m_valid = 1'b0;
        end else if (ss2) begin
            m_instr = f;
            m_pcd   = m_pc;
            m_p4d   = p4;
            m_valid = 1'b1;
        end
        m_pc = pcsrc ? target : (ss1 ? p4 : m_pc);
        @(posedge clk);
        #1;
        check_all(ph);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        ss1 = 1'b1; ss2 = 1'b1;
        step("run0");
        chk("run0.InstrD_lag", bus.InstrD, mem(32'h0));
        step("run1");
        chk("run1.PCF_eq_8", bus.PCF, 32'h8);
        chk("run1.PCD_eq_4", bus.PCD, 32'h4);

        ss1 = 1'b0; ss2 = 1'b0;
        step("stall0");
        step("stall1");
        chk("stall.PCF_held", bus.PCF, 32'h8);
        chk("stall.PCD_held", bus.PCD, 32'h4);
        chk("stall.cnt_2", 32'(bus.stall_cnt), 32'd2);
        ss1 = 1'b1; ss2 = 1'b1;
        step("release");
        chk("release.PCF_C", bus.PCF, 32'hC);

        pcsrc = 1'b1; target = 32'h100; ss1 = 1'b0; ss2 = 1'b0;
        step("redir_stall");
        chk("redir.PCF_100", bus.PCF, 32'h100);
        chk("redir.nop", bus.InstrD, 32'h0000_0013);
        chk("redir.valid0", {31'd0, bus.ValidD}, 32'd0);
        chk("redir.flush1", 32'(bus.flush_cnt), 32'd1);
        chk("redir.stall_same", 32'(bus.stall_cnt), 32'd2);

        target = 32'hFFFF_FFFC; ss1 = 1'b1; ss2 = 1'b1;
        step("redir_top");
        pcsrc = 1'b0;
        step("wrap");
        chk("wrap.PCF_0", bus.PCF, 32'h0);
        chk("wrap.PCPlus4D_0", bus.PCPlus4D, 32'h0);
        chk("wrap.PCD_top", bus.PCD, 32'hFFFF_FFFC);

        ss1 = 1'b0; ss2 = 1'b1;
        for (int i = 0; i < 20; i++) step("sat");
        chk("sat.stall4_15", 32'(bus4.stall_cnt), 32'd15);

        for (int i = 0; i < 300; i++) begin
            ss1    = ($urandom_range(0, 3) != 0);
            ss2    = ($urandom_range(0, 3) != 0);
            pcsrc  = ($urandom_range(0, 5) == 0);
            target = $urandom() & 32'hFFFF_FFFC;
            step("rand");
        end

        pcsrc = 1'b1; target = 32'h0000_0400; ss1 = 1'b0; ss2 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst_n = 1'b1; pcsrc = 1'b0; ss1 = 1'b1; ss2 = 1'b1;
        chk("post_rst.PCF", bus.PCF, 32'h0);
        step("post_rst");
        chk("post_rst.PCF_4", bus.PCF, 32'h4);
        chk("post_rst.InstrD", bus.InstrD, mem(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
